alu_seq: RTL

- Parametrised, handshaked successor to the combinational ALU stage; executes one instruction-ID-encoded operation per transaction and returns the result plus next PC.
- Logic/add/sub ops complete in 1 cycle; shifts run on an iterative multi-cycle shifter, so the block owns a small FSM and valid/ready on both sides.
- Sits between decode (operands rs/rt, instr ID, PC) and writeback/PC update in the processor datapath.

---
 rtl/alu_seq.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU stage. Logic/add/sub ops complete in one cycle,
// sll/srl run on an iterative shifter that moves up to SH_STEP bits/cycle.
//
// Handshake: a request is taken on the rising edge where in_valid && in_ready;
// a result is consumed on the rising edge where out_valid && out_ready. Once
// out_valid rises it stays high, with result/pc_out/ovf/err frozen, until the
// consumer takes it.
module alu_seq #(
  parameter int DATA_W  = 32,
  parameter int ID_W    = 32,
  parameter int SH_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ID_W-1:0]   instr_id,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] pc_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] pc_out,
  output logic              ovf,
  output logic              err,
  output logic [1:0]        dbg_state
);

  // Shift amount width, plus one extra bit so the step size (up to DATA_W)
  // and the remaining count share one width.
  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = SH_W + 1;
  localparam int MSB   = DATA_W - 1;
  localparam logic [CNT_W-1:0] STEP = CNT_W'(SH_STEP);

  localparam logic [ID_W-1:0] OP_ADD   = ID_W'(1);
  localparam logic [ID_W-1:0] OP_SUB   = ID_W'(2);
  localparam logic [ID_W-1:0] OP_ADDU  = ID_W'(3);
  localparam logic [ID_W-1:0] OP_SUBU  = ID_W'(4);
  localparam logic [ID_W-1:0] OP_ADDI  = ID_W'(5);
  localparam logic [ID_W-1:0] OP_ADDIU = ID_W'(6);
  localparam logic [ID_W-1:0] OP_AND   = ID_W'(7);
  localparam logic [ID_W-1:0] OP_OR    = ID_W'(8);
  localparam logic [ID_W-1:0] OP_ANDI  = ID_W'(9);
  localparam logic [ID_W-1:0] OP_ORI   = ID_W'(10);
  localparam logic [ID_W-1:0] OP_SLL   = ID_W'(11);
  localparam logic [ID_W-1:0] OP_SRL   = ID_W'(12);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  // r_result doubles as the shifter working register while in S_SHIFT.
  logic [DATA_W-1:0]   r_result;
  logic [DATA_W-1:0]   r_pc;
  logic                r_ovf;
  logic                r_err;
  logic                r_shift_left;
  logic [CNT_W-1:0]    r_rem;

  logic [DATA_W-1:0]   w_sum;
  logic [DATA_W-1:0]   w_diff;
  logic [DATA_W-1:0]   w_op_result;
  logic                w_op_ovf;
  logic                w_op_err;
  logic                w_is_shift;
  logic                w_shift_left;
  logic [CNT_W-1:0]    w_shamt;
  logic                w_start_shift;
  logic                w_accept;
  logic [CNT_W-1:0]    w_step;
  logic [CNT_W-1:0]    w_rem_next;
  logic [DATA_W-1:0]   w_shifted;

  assign w_sum         = a + b;
  assign w_diff        = a - b;
  assign w_shamt       = {1'b0, b[SH_W-1:0]};
  assign w_start_shift = w_is_shift && (w_shamt != '0);

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && in_ready;

  assign result    = r_result;
  assign pc_out    = r_pc;
  assign ovf       = r_ovf;
  assign err       = r_err;
  assign dbg_state = r_state;

  // Shifter step: move min(SH_STEP, remaining) positions this cycle.
  assign w_step     = (r_rem > STEP) ? STEP : r_rem;
  assign w_rem_next = r_rem - w_step;
  assign w_shifted  = r_shift_left ? (r_result << w_step) : (r_result >> w_step);

  // Decode the instruction ID and compute single-cycle results; shifts
  // pass operand a through as the initial working value.
  always_comb begin
    w_op_result  = '0;
    w_op_ovf     = 1'b0;
    w_op_err     = 1'b0;
    w_is_shift   = 1'b0;
    w_shift_left = 1'b0;
    case (instr_id)
      OP_ADD, OP_ADDI: begin
        w_op_result = w_sum;
        w_op_ovf    = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        w_op_result = w_diff;
        w_op_ovf    = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
      end
      OP_ADDU, OP_ADDIU: w_op_result = w_sum;
      OP_SUBU:           w_op_result = w_diff;
      OP_AND, OP_ANDI:   w_op_result = a & b;
      OP_OR, OP_ORI:     w_op_result = a | b;
      OP_SLL: begin
        w_op_result  = a;
        w_is_shift   = 1'b1;
        w_shift_left = 1'b1;
      end
      OP_SRL: begin
        w_op_result = a;
        w_is_shift  = 1'b1;
      end
      default: w_op_err = 1'b1;
    endcase
  end

  // Next-state logic: accepts go to SHIFT only for a non-zero shift amount.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = w_start_shift ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        if (w_rem_next == '0) w_next_state = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          if (in_valid) w_next_state = w_start_shift ? S_SHIFT : S_DONE;
          else          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Datapath: capture operands on accept, iterate the shifter in S_SHIFT,
  // otherwise hold so outputs stay stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result     <= '0;
      r_pc         <= '0;
      r_ovf        <= 1'b0;
      r_err        <= 1'b0;
      r_shift_left <= 1'b0;
      r_rem        <= '0;
    end else if (w_accept) begin
      r_result     <= w_op_result;
      r_pc         <= pc_in + DATA_W'(4);
      r_ovf        <= w_op_ovf;
      r_err        <= w_op_err;
      r_shift_left <= w_shift_left;
      r_rem        <= w_start_shift ? w_shamt : '0;
    end else if (r_state == S_SHIFT) begin
      r_result <= w_shifted;
      r_rem    <= w_rem_next;
    end
  end

endmodule
